// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if -- data-memory bus between the MEM pipeline stage and memory.
//
// Signals (names seen from the stage side):
//   mem_req_o    stage -> mem  access request, held until mem_ack_i
//   mem_we_o     stage -> mem  write enable (store)
//   mem_addr_o   stage -> mem  word-aligned byte address
//   mem_wdata_o  stage -> mem  lane-replicated store data
//   mem_be_o     stage -> mem  byte enables, bit n = byte lane n
//   mem_ack_i    mem -> stage  access complete
//   mem_rdata_i  mem -> stage  read data, valid with mem_ack_i
//
// Modports: master = MEM stage, slave = memory / bus fabric.
// ---------------------------------------------------------------------------
interface mem_stage_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- pipeline MEM stage: passes non-memory results straight to
// write-back (latency 1) and runs byte/half/word loads and stores on a
// request/ack data bus with an ack timeout.
//
// Parameters:
//   ACK_TIMEOUT  wait-counter value at which an unacknowledged access is
//                aborted with bus_err_o.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   valid_i / ready_o     EX-stage handshake; ready_o is high only in IDLE
//   circuit_sel_i         [8] load, [9] store, [1:0] size, [2] zero-extend
//   memory_address_i      effective address
//   result_i, result2_i   EX results (result_i is store data)
//   destination_i/2_i     destination registers
//   mem                   data bus (mem_stage_if.master)
//   wb_valid_o            one-cycle completion pulse
//   wb_data_o/2_o         write-back values
//   wb_dest_o/2_o         write-back registers, 0 = no write
//   bus_err_o             completion was an ack timeout
//   misalign_o            completion was a rejected misaligned access
//
// Build option:
//   MEM_MISALIGN_CHECK_EN  when defined, misaligned half/word accesses are
//                          rejected without a bus cycle; otherwise the low
//                          address bits are forced to alignment.
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [9:0]   circuit_sel_i,
  input  logic [31:0]  memory_address_i,
  input  logic [31:0]  result_i,
  input  logic [31:0]  result2_i,
  input  logic [4:0]   destination_i,
  input  logic [4:0]   destination2_i,
  mem_stage_if.master  mem,
  output logic         wb_valid_o,
  output logic [31:0]  wb_data_o,
  output logic [31:0]  wb_data2_o,
  output logic [4:0]   wb_dest_o,
  output logic [4:0]   wb_dest2_o,
  output logic         bus_err_o,
  output logic         misalign_o
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e state_q, state_d;

  // Bus-side registers
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [31:0]       mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q,    mem_be_d;

  // Write-back registers
  logic              wb_valid_q,  wb_valid_d;
  logic [31:0]       wb_data_q,   wb_data_d;
  logic [31:0]       wb_data2_q,  wb_data2_d;
  logic [4:0]        wb_dest_q,   wb_dest_d;
  logic [4:0]        wb_dest2_q,  wb_dest2_d;
  logic              bus_err_q,   bus_err_d;
  logic              misalign_q,  misalign_d;

  // Latched operation, used when the ack returns
  logic              op_load_q,   op_load_d;
  logic [1:0]        op_size_q,   op_size_d;
  logic              op_zext_q,   op_zext_d;
  logic [1:0]        op_lo_q,     op_lo_d;
  logic [4:0]        op_dest_q,   op_dest_d;

  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  // Request decode
  logic        sel_mem;
  logic        sel_store;
  logic [1:0]  sel_size;
  logic [1:0]  acc_lo;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic        acc_misaligned;
  logic        timeout_hit;
  logic [31:0] rd_shift;
  logic [31:0] load_val;
  logic        sel_unused;

  assign sel_mem    = |circuit_sel_i[9:8];
  assign sel_store  = circuit_sel_i[9];
  assign sel_size   = circuit_sel_i[1:0];
  assign sel_unused = ^circuit_sel_i[7:3];

  // Lane offset, byte enables and replicated store data. Size 2'b11 is
  // handled as a word access.
  always_comb begin
    acc_lo    = memory_address_i[1:0];
    acc_be    = 4'b1111;
    acc_wdata = result_i;
    unique case (sel_size)
      2'b00: begin
        acc_be    = 4'b0001 << acc_lo;
        acc_wdata = {4{result_i[7:0]}};
      end
      2'b01: begin
        acc_lo    = {memory_address_i[1], 1'b0};
        acc_be    = 4'b0011 << acc_lo;
        acc_wdata = {2{result_i[15:0]}};
      end
      default: acc_lo = 2'b00;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign acc_misaligned = (sel_size == 2'b01) ? memory_address_i[0]
                        : (sel_size[1]        ? |memory_address_i[1:0] : 1'b0);
`else
  assign acc_misaligned = 1'b0;
`endif

  // Ack in the same cycle as the timeout takes priority (see next-state).
  assign timeout_hit = (cnt_q == CNT_W'(ACK_TIMEOUT));

  // Select the addressed lane of the read data and extend it.
  always_comb begin
    rd_shift = mem.mem_rdata_i >> {op_lo_q, 3'b000};
    unique case (op_size_q)
      2'b00:   load_val = op_zext_q ? {24'h0, rd_shift[7:0]}
                                    : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = op_zext_q ? {16'h0, rd_shift[15:0]}
                                    : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = mem.mem_rdata_i;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_i && sel_mem) begin
          state_d = acc_misaligned ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem.mem_ack_i || timeout_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic. All outputs are registered, so the pulse
  // flops are set in the cycle that transitions into DONE.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    wb_data2_d  = wb_data2_q;
    wb_dest_d   = wb_dest_q;
    wb_dest2_d  = wb_dest2_q;
    bus_err_d   = 1'b0;
    misalign_d  = 1'b0;
    op_load_d   = op_load_q;
    op_size_d   = op_size_q;
    op_zext_d   = op_zext_q;
    op_lo_d     = op_lo_q;
    op_dest_d   = op_dest_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (valid_i && !sel_mem) begin
          wb_valid_d = 1'b1;
          wb_data_d  = result_i;
          wb_data2_d = result2_i;
          wb_dest_d  = destination_i;
          wb_dest2_d = destination2_i;
        end else if (valid_i && acc_misaligned) begin
          wb_valid_d = 1'b1;
          misalign_d = 1'b1;
          wb_data_d  = '0;
          wb_data2_d = '0;
          wb_dest_d  = '0;
          wb_dest2_d = '0;
        end else if (valid_i) begin
          mem_req_d   = 1'b1;
          mem_we_d    = sel_store;
          mem_addr_d  = {memory_address_i[31:2], 2'b00};
          mem_be_d    = acc_be;
          mem_wdata_d = acc_wdata;
          op_load_d   = !sel_store;
          op_size_d   = sel_size;
          op_zext_d   = circuit_sel_i[2];
          op_lo_d     = acc_lo;
          op_dest_d   = destination_i;
          cnt_d       = '0;
        end
      end
      ST_WAIT: begin
        if (mem.mem_ack_i) begin
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = op_load_q ? load_val : '0;
          wb_data2_d = '0;
          wb_dest_d  = op_load_q ? op_dest_q : '0;
          wb_dest2_d = '0;
        end else if (timeout_hit) begin
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          wb_valid_d = 1'b1;
          bus_err_d  = 1'b1;
          wb_data_d  = '0;
          wb_data2_d = '0;
          wb_dest_d  = '0;
          wb_dest2_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_data2_q  <= '0;
      wb_dest_q   <= '0;
      wb_dest2_q  <= '0;
      bus_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
      op_load_q   <= 1'b0;
      op_size_q   <= '0;
      op_zext_q   <= 1'b0;
      op_lo_q     <= '0;
      op_dest_q   <= '0;
      cnt_q       <= '0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_data2_q  <= wb_data2_d;
      wb_dest_q   <= wb_dest_d;
      wb_dest2_q  <= wb_dest2_d;
      bus_err_q   <= bus_err_d;
      misalign_q  <= misalign_d;
      op_load_q   <= op_load_d;
      op_size_q   <= op_size_d;
      op_zext_q   <= op_zext_d;
      op_lo_q     <= op_lo_d;
      op_dest_q   <= op_dest_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ready_o         = (state_q == ST_IDLE);
  assign mem.mem_req_o   = mem_req_q;
  assign mem.mem_we_o    = mem_we_q;
  assign mem.mem_addr_o  = mem_addr_q;
  assign mem.mem_wdata_o = mem_wdata_q;
  assign mem.mem_be_o    = mem_be_q;
  assign wb_valid_o      = wb_valid_q;
  assign wb_data_o       = wb_data_q;
  assign wb_data2_o      = wb_data2_q;
  assign wb_dest_o       = wb_dest_q;
  assign wb_dest2_o      = wb_dest2_q;
  assign bus_err_o       = bus_err_q;
  assign misalign_o      = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int unsigned TO = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [9:0]  circuit_sel_i = '0;
  logic [31:0] memory_address_i = '0;
  logic [31:0] result_i = '0;
  logic [31:0] result2_i = '0;
  logic [4:0]  destination_i = '0;
  logic [4:0]  destination2_i = '0;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data2_o;
  logic [4:0]  wb_dest_o;
  logic [4:0]  wb_dest2_o;
  logic        bus_err_o;
  logic        misalign_o;

  mem_stage_if mem_if ();

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .circuit_sel_i    (circuit_sel_i),
    .memory_address_i (memory_address_i),
    .result_i         (result_i),
    .result2_i        (result2_i),
    .destination_i    (destination_i),
    .destination2_i   (destination2_i),
    .mem              (mem_if),
    .wb_valid_o       (wb_valid_o),
    .wb_data_o        (wb_data_o),
    .wb_data2_o       (wb_data2_o),
    .wb_dest_o        (wb_dest_o),
    .wb_dest2_o       (wb_dest2_o),
    .bus_err_o        (bus_err_o),
    .misalign_o       (misalign_o)
  );

  always #5 clk = ~clk;

  // delay = cycles from first request cycle to ack; delay > TO means no ack.
  typedef struct {
    logic [9:0]  sel;
    logic [31:0] addr;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  d1;
    logic [4:0]  d2;
    int unsigned delay;
    logic [31:0] rdata;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic [31:0] exp_wb;
    logic [4:0]  exp_dest;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-lane arithmetic straight from the access rules.
  function automatic vec_t make_vec(input logic [9:0] sel, input logic [31:0] addr,
                                    input logic [31:0] r1, input logic [31:0] r2,
                                    input logic [4:0] d1, input logic [4:0] d2,
                                    input int unsigned delay, input logic [31:0] rdata);
    vec_t v;
    int unsigned nbytes, off;
    logic [31:0] lane;
    logic is_mem, is_load;
    v.sel = sel; v.addr = addr; v.r1 = r1; v.r2 = r2; v.d1 = d1; v.d2 = d2;
    v.delay = delay; v.rdata = rdata;
    is_mem  = sel[9] || sel[8];
    is_load = is_mem && !sel[9];
    nbytes  = (sel[1:0] == 2'b00) ? 1 : (sel[1:0] == 2'b01) ? 2 : 4;
    off     = addr % 4;
    v.exp_mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    v.exp_mis = is_mem && ((off % nbytes) != 0);
`endif
    off = off - (off % nbytes);
    v.exp_addr = addr - (addr % 4);
    v.exp_be   = 4'(((1 << nbytes) - 1) << off);
    if (nbytes == 1)      v.exp_wdata = (r1 & 32'hFF) * 32'h0101_0101;
    else if (nbytes == 2) v.exp_wdata = (r1 & 32'hFFFF) * 32'h0001_0001;
    else                  v.exp_wdata = r1;
    v.exp_we = sel[9];
    lane = rdata >> (8 * off);
    if (nbytes < 4) begin
      lane = lane % (32'd1 << (8 * nbytes));
      if (!sel[2] && lane >= (32'd1 << (8 * nbytes - 1)))
        lane = lane - (32'd1 << (8 * nbytes));
    end
    if (!is_mem) begin
      v.exp_wb = r1; v.exp_dest = d1;
    end else begin
      v.exp_wb   = is_load ? lane : 32'h0;
      v.exp_dest = (is_load && !v.exp_mis && delay <= TO) ? d1 : 5'd0;
    end
    return v;
  endfunction

  task automatic garbage();
    valid_i          = 1'($urandom_range(0, 1));
    circuit_sel_i    = 10'($urandom);
    memory_address_i = $urandom;
    result_i         = $urandom;
    destination_i    = 5'($urandom);
  endtask

  task automatic check_bus(input vec_t v);
    check("bus_req", mem_if.mem_req_o, 1'b1);
    check("bus_we", mem_if.mem_we_o, v.exp_we);
    check("bus_addr", mem_if.mem_addr_o, v.exp_addr);
    check("bus_be", mem_if.mem_be_o, v.exp_be);
    if (v.exp_we) check("bus_wdata", mem_if.mem_wdata_o, v.exp_wdata);
    check("wait_wb_valid", wb_valid_o, 1'b0);
    check("wait_ready", ready_o, 1'b0);
  endtask

  task automatic run_op(input vec_t v);
    logic is_mem, is_store, tmo;
    is_mem   = v.sel[9] || v.sel[8];
    is_store = v.sel[9];
    tmo      = v.delay > TO;
    @(negedge clk);
    check("ready_before", ready_o, 1'b1);
    valid_i = 1'b1; circuit_sel_i = v.sel; memory_address_i = v.addr;
    result_i = v.r1; result2_i = v.r2; destination_i = v.d1; destination2_i = v.d2;
    @(negedge clk);
    if (!is_mem) begin
      valid_i = 1'b0;
      check("nm_wb_valid", wb_valid_o, 1'b1);
      check("nm_wb_data", wb_data_o, v.exp_wb);
      check("nm_wb_data2", wb_data2_o, v.r2);
      check("nm_wb_dest", wb_dest_o, v.exp_dest);
      check("nm_wb_dest2", wb_dest2_o, v.d2);
      check("nm_req", mem_if.mem_req_o, 1'b0);
      check("nm_ready", ready_o, 1'b1);
      check("nm_bus_err", bus_err_o, 1'b0);
      check("nm_misalign", misalign_o, 1'b0);
    end else if (v.exp_mis) begin
      valid_i = 1'b0;
      check("mis_req", mem_if.mem_req_o, 1'b0);
      check("mis_wb_valid", wb_valid_o, 1'b1);
      check("mis_flag", misalign_o, 1'b1);
      check("mis_dest", wb_dest_o, 5'd0);
      check("mis_bus_err", bus_err_o, 1'b0);
    end else begin
      for (int unsigned k = 0; k < v.delay; k++) begin
        check_bus(v);
        garbage();
        @(negedge clk);
      end
      if (tmo) begin
        check("tmo_req", mem_if.mem_req_o, 1'b0);
        check("tmo_wb_valid", wb_valid_o, 1'b1);
        check("tmo_bus_err", bus_err_o, 1'b1);
        check("tmo_dest", wb_dest_o, 5'd0);
        check("tmo_misalign", misalign_o, 1'b0);
      end else begin
        check_bus(v);
        mem_if.mem_ack_i = 1'b1; mem_if.mem_rdata_i = v.rdata;
        @(negedge clk);
        mem_if.mem_ack_i = 1'b0; mem_if.mem_rdata_i = $urandom;
        check("ack_req_drop", mem_if.mem_req_o, 1'b0);
        check("ack_wb_valid", wb_valid_o, 1'b1);
        check("ack_bus_err", bus_err_o, 1'b0);
        check("ack_misalign", misalign_o, 1'b0);
        check("ack_dest", wb_dest_o, v.exp_dest);
        if (is_store) check("st_dest2", wb_dest2_o, 5'd0);
        else          check("ld_data", wb_data_o, v.exp_wb);
      end
      valid_i = 1'b0;
    end
    @(negedge clk);
    check("post_wb_valid", wb_valid_o, 1'b0);
    check("post_ready", ready_o, 1'b1);
    check("post_req", mem_if.mem_req_o, 1'b0);
    check("post_bus_err", bus_err_o, 1'b0);
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{10'h000, 32'h0000_0040, 32'h1234_5678, 32'hCAFE_F00D, 5'd7, 5'd9, 0, 32'h0,
                1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h1234_5678, 5'd7};
    tbl[1]  = '{10'h100, 32'h0000_1003, 32'h0, 32'h0, 5'd5, 5'd6, 2, 32'h8011_2233,
                1'b0, 32'h0000_1000, 4'b1000, 32'h0, 1'b0, 32'hFFFF_FF80, 5'd5};
    tbl[2]  = '{10'h201, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 5'd8, 5'd10, 1, 32'h0,
                1'b0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1'b1, 32'h0, 5'd0};
`ifdef MEM_MISALIGN_CHECK_EN
    tbl[3]  = '{10'h102, 32'h0000_3001, 32'h0, 32'h0, 5'd11, 5'd12, 0, 32'hDEAD_BEEF,
                1'b1, 32'h0000_3000, 4'b1111, 32'h0, 1'b0, 32'h0, 5'd0};
`else
    tbl[3]  = '{10'h102, 32'h0000_3001, 32'h0, 32'h0, 5'd11, 5'd12, 0, 32'hDEAD_BEEF,
                1'b0, 32'h0000_3000, 4'b1111, 32'h0, 1'b0, 32'hDEAD_BEEF, 5'd11};
`endif
    tbl[4]  = '{10'h105, 32'h4000_0006, 32'h0, 32'h0, 5'd13, 5'd14, 3, 32'h8765_4321,
                1'b0, 32'h4000_0004, 4'b1100, 32'h0, 1'b0, 32'h0000_8765, 5'd13};
    tbl[5]  = '{10'h101, 32'h4000_0004, 32'h0, 32'h0, 5'd15, 5'd16, 0, 32'h1234_8001,
                1'b0, 32'h4000_0004, 4'b0011, 32'h0, 1'b0, 32'hFFFF_8001, 5'd15};
    tbl[6]  = '{10'h104, 32'h0000_5001, 32'h0, 32'h0, 5'd17, 5'd18, 1, 32'h0000_A500,
                1'b0, 32'h0000_5000, 4'b0010, 32'h0, 1'b0, 32'h0000_00A5, 5'd17};
    tbl[7]  = '{10'h200, 32'h0000_6001, 32'h1234_56AB, 32'h0, 5'd19, 5'd20, 2, 32'h0,
                1'b0, 32'h0000_6000, 4'b0010, 32'hABAB_ABAB, 1'b1, 32'h0, 5'd0};
    tbl[8]  = '{10'h202, 32'h0000_7004, 32'hA5A5_5A5A, 32'h0, 5'd21, 5'd22, 0, 32'h0,
                1'b0, 32'h0000_7004, 4'b1111, 32'hA5A5_5A5A, 1'b1, 32'h0, 5'd0};
    tbl[9]  = '{10'h102, 32'h0000_8000, 32'h0, 32'h0, 5'd23, 5'd24, TO, 32'h1122_3344,
                1'b0, 32'h0000_8000, 4'b1111, 32'h0, 1'b0, 32'h1122_3344, 5'd23};
    tbl[10] = '{10'h100, 32'h0000_9000, 32'h0, 32'h0, 5'd3, 5'd4, TO + 1, 32'h0,
                1'b0, 32'h0000_9000, 4'b0001, 32'h0, 1'b0, 32'h0, 5'd0};

    mem_if.mem_ack_i   = 1'b0;
    mem_if.mem_rdata_i = '0;

    // Values held during reset
    #12;
    check("rst_ready", ready_o, 1'b1);
    check("rst_req", mem_if.mem_req_o, 1'b0);
    check("rst_we", mem_if.mem_we_o, 1'b0);
    check("rst_addr", mem_if.mem_addr_o, 32'h0);
    check("rst_be", mem_if.mem_be_o, 4'h0);
    check("rst_wdata", mem_if.mem_wdata_o, 32'h0);
    check("rst_wb_valid", wb_valid_o, 1'b0);
    check("rst_wb_data", wb_data_o, 32'h0);
    check("rst_wb_dest", wb_dest_o, 5'd0);
    check("rst_bus_err", bus_err_o, 1'b0);
    check("rst_misalign", misalign_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_op(tbl[i]);

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [9:0] sel;
      int unsigned kind;
      kind = $urandom_range(0, 2);
      sel = 10'($urandom);
      sel[9:8] = (kind == 0) ? 2'b00 : (kind == 1) ? 2'b01 : 2'b10;
      sel[1:0] = 2'($urandom_range(0, 2));
      run_op(make_vec(sel, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
                      $urandom_range(0, 4), $urandom));
    end

    // Asynchronous reset in the middle of a wait
    @(negedge clk);
    valid_i = 1'b1; circuit_sel_i = 10'h102; memory_address_i = 32'h0000_A000;
    destination_i = 5'd9;
    @(negedge clk);
    valid_i = 1'b0;
    check("mid_req_before", mem_if.mem_req_o, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", mem_if.mem_req_o, 1'b0);
    check("mid_rst_ready", ready_o, 1'b1);
    check("mid_rst_wb_valid", wb_valid_o, 1'b0);
    check("mid_rst_be", mem_if.mem_be_o, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_ready", ready_o, 1'b1);
      check("post_rst_wb_valid", wb_valid_o, 1'b0);
      check("post_rst_req", mem_if.mem_req_o, 1'b0);
    end

    // Stage still works after the reset
    run_op(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
